// File: rtl/data_mem_resp.sv
// data_mem_resp: single-outstanding data RAM with fixed response latency and a tohost halt register.
module data_mem_resp #(
  parameter int          ADDR_W      = 10,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        halt,
  output logic [31:0] halt_code
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [2:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              mis, host, in_rng, exec;
  assign idx       = addr_q[ADDR_W+1:2];
  assign mis       = addr_q[1:0] != 2'b00;
  assign host      = addr_q == TOHOST_ADDR;
  assign in_rng    = (addr_q >> (ADDR_W + 2)) == 32'd0;
  // reset on the execute edge must abort the access, including the RAM write
  assign exec      = !rst && state == WAIT && cnt == 3'd0;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (exec && we_q && !mis && !host && in_rng && wstrb_q[i])
        mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      halt      <= 1'b0;
      halt_code <= 32'd0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          wstrb_q <= req_wstrb;
          cnt     <= 3'(LATENCY - 1);
          state   <= WAIT;
        end
        WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        else begin
          state     <= RESP;
          rsp_err   <= mis || (!host && !in_rng);
          rsp_rdata <= (mis || we_q) ? 32'd0 : host ? halt_code : in_rng ? mem[idx] : 32'd0;
          if (!mis && host && we_q) begin
            halt      <= 1'b1;
            halt_code <= wdata_q;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address bits; RAM depth = 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid; legal range 1..7.
REQ-003 Parameter TOHOST_ADDR, default 32'h0000_1000, byte address of the halt/result register.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  CPU presents a load/store request.
REQ-007 req_ready  output  1  block accepts the request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  store byte enables; bit i enables wdata[8i+7:8i].
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  CPU accepts the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access fault for this response.
REQ-016 halt  output  1  sticky: the program has written TOHOST_ADDR.
REQ-017 halt_code  output  32  last word written to TOHOST_ADDR.

Function
REQ-018 FSM states IDLE, WAIT, RESP; at most one outstanding request.
REQ-019 IDLE: req_ready=1, rsp_valid=0; on req_valid the block latches we/addr/wdata/wstrb, loads counter=LATENCY-1, and enters WAIT.
REQ-020 WAIT: req_ready=0; counter decrements each cycle; when counter==0 the access executes and the FSM enters RESP next cycle, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-021 RESP: rsp_valid=1; rsp_rdata/rsp_err stay stable until rsp_ready=1; on rsp_valid&rsp_ready the FSM returns to IDLE; req_ready stays 0 in RESP (no back-to-back accept on the same edge).
REQ-022 Word index = addr[ADDR_W+1:2]; in range iff addr < 4*2^ADDR_W.
REQ-023 Misaligned (addr[1:0]!=0) -> rsp_err=1, no state change, rsp_rdata=0.
REQ-024 Out-of-range address other than TOHOST_ADDR -> rsp_err=1, no state change, rsp_rdata=0.
REQ-025 In-range store: only the lanes enabled by wstrb update; wstrb=4'b0000 is a legal no-op with rsp_err=0.
REQ-026 In-range load: rsp_rdata = full word at that index, including any earlier store completed before this request.
REQ-027 Store to TOHOST_ADDR: halt_code <= req_wdata (wstrb ignored), halt <= 1; rsp_err=0.
REQ-028 Load from TOHOST_ADDR returns halt_code, rsp_err=0.
REQ-029 Once set, halt stays 1 until rst; later requests are still serviced normally.
REQ-030 req_* inputs are ignored outside IDLE; changes during WAIT/RESP have no effect.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, halt=0, halt_code=0; req_ready=1 from the first cycle after rst deasserts.
REQ-032 rst during WAIT aborts the request: a store not yet executed does not modify RAM and no response is issued.
REQ-033 RAM contents are not initialised by rst and survive it.

Verification
REQ-034 LATENCY=2: store 0xDEADBEEF, wstrb=4'hF, to 0x10; load 0x10 -> rsp_valid exactly 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-035 Store 0x11223344 wstrb=4'b0101 over 0xDEADBEEF at 0x10; load -> 0xDE22BE44.
REQ-036 Load at 0x13 and at 0x1000_0000 -> rsp_err=1, rdata=0; a load at 0x10 returns the unchanged word.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata, err stable and req_ready=0 throughout; one cycle after the handshake req_ready=1.
REQ-038 Store 0x00000001 to 0x1000 -> halt=1, halt_code=1 on the response cycle; load 0x1000 returns 1; rst clears both to 0.
REQ-039 Store 0xAAAAAAAA to 0x20, assert rst in WAIT -> no response; after reset, load 0x20 returns the value stored there before the aborted store.
